serial_subtractor: RTL and testbench

Parametrised multi-cycle subtractor computing D = A − B − Bin over WIDTH-bit operands, processing DIGIT bits per clock through a chain of DIGIT full-subtract cells with a registered borrow. It generalises the single-bit half subtractor into a word-level arithmetic unit with a start/done handshake, borrow-in, and signed/unsigned status flags. It trades area for latency in datapaths where a full WIDTH-bit ripple subtractor is too large.

---
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: D = A - B - Bin over WIDTH bits, DIGIT bits per clock,
// with a start/done handshake and unsigned-borrow / signed-overflow / zero flags.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_subtractor: illegal WIDTH/DIGIT combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff_sh;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT:0]   w_br;
  logic [DIGIT-1:0] w_d;
  logic [WIDTH-1:0] w_diff_next;
  logic             w_last;

  // Ripple-borrow chain of DIGIT full-subtract cells fed by the registered borrow.
  assign w_br[0] = r_borrow;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign w_d[i]    = r_a[i] ^ r_b[i] ^ w_br[i];
    assign w_br[i+1] = (~r_a[i] & r_b[i]) | (~(r_a[i] ^ r_b[i]) & w_br[i]);
  end

  // New digit enters at the top; after N steps the first digit sits at bit 0.
  assign w_diff_next = (r_diff_sh >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));
  assign w_last      = (r_cnt == CW'(N - 1));

  // NOTE: every register here is written with <= so all updates in a cycle see
  // the pre-edge values; blocking assignments would make the shift order-dependent.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_diff_sh <= '0;
      r_borrow  <= 1'b0;
      r_cnt     <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_diff    <= '0;
      o_bout    <= 1'b0;
      o_ovf     <= 1'b0;
      o_zero    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_borrow <= i_bin;
            r_cnt    <= '0;
            o_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_a       <= r_a >> DIGIT;
          r_b       <= r_b >> DIGIT;
          r_diff_sh <= w_diff_next;
          r_borrow  <= w_br[DIGIT];
          r_cnt     <= r_cnt + CW'(1);
          if (w_last) begin
            // On the last digit, w_br[DIGIT-1] is the borrow entering the MSB.
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_diff  <= w_diff_next;
            o_bout  <= w_br[DIGIT];
            o_ovf   <= w_br[DIGIT-1] ^ w_br[DIGIT];
            o_zero  <= (w_diff_next == '0);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: three instances (8/1, 16/4, 8/8), expected
// results queued at issue time and popped by a monitor on every done pulse.
module tb_serial_subtractor;

  localparam int N0 = 8;
  localparam int N1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DUT0: WIDTH=8, DIGIT=1
  logic       rst0 = 1'b1, start0 = 1'b0, bin0 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0;
  logic       busy0, done0, bout0, ovf0, zero0;
  logic [7:0] diff0;
  // DUT1: WIDTH=16, DIGIT=4
  logic        rst1 = 1'b1, start1 = 1'b0, bin1 = 1'b0;
  logic [15:0] a1 = '0, b1 = '0;
  logic        busy1, done1, bout1, ovf1, zero1;
  logic [15:0] diff1;
  // DUT2: WIDTH=8, DIGIT=8
  logic       rst2 = 1'b1, start2 = 1'b0, bin2 = 1'b0;
  logic [7:0] a2 = '0, b2 = '0;
  logic       busy2, done2, bout2, ovf2, zero2;
  logic [7:0] diff2;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u0 (
    .i_clk(clk), .i_rst(rst0), .i_start(start0), .i_a(a0), .i_b(b0), .i_bin(bin0),
    .o_busy(busy0), .o_done(done0), .o_diff(diff0), .o_bout(bout0), .o_ovf(ovf0), .o_zero(zero0));
  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u1 (
    .i_clk(clk), .i_rst(rst1), .i_start(start1), .i_a(a1), .i_b(b1), .i_bin(bin1),
    .o_busy(busy1), .o_done(done1), .o_diff(diff1), .o_bout(bout1), .o_ovf(ovf1), .o_zero(zero1));
  serial_subtractor #(.WIDTH(8), .DIGIT(8)) u2 (
    .i_clk(clk), .i_rst(rst2), .i_start(start2), .i_a(a2), .i_b(b2), .i_bin(bin2),
    .o_busy(busy2), .o_done(done2), .o_diff(diff2), .o_bout(bout2), .o_ovf(ovf2), .o_zero(zero2));

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] prev0 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packed result: {diff, bout, ovf, zero}
  function automatic logic [31:0] pk(input logic [15:0] d, input logic bo, input logic ov,
                                     input logic z);
    return {13'd0, d, bo, ov, z};
  endfunction

  // Integer reference model, independent of any bit-level borrow chain.
  function automatic logic [31:0] model(input int w, input int ua, input int ub, input int bi);
    int half, full, du, sa, sb, s, d;
    half = 1 << (w - 1);
    full = 1 << w;
    du   = ua - ub - bi;
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    s    = sa - sb - bi;
    d    = du & (full - 1);
    return pk(16'(d), du < 0, (s < -half) || (s >= half), d == 0);
  endfunction

  // Monitor: pops one expected entry per done pulse, and checks busy/done exclusivity.
  always @(negedge clk) begin
    logic [31:0] e;
    check("busy_done_excl0", 32'(busy0 & done0), 0);
    check("busy_done_excl1", 32'(busy1 & done1), 0);
    check("busy_done_excl2", 32'(busy2 & done2), 0);
    if (done0) begin
      check("sb0_expected_done", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("res0", pk(16'(diff0), bout0, ovf0, zero0), e);
      end
    end
    if (done1) begin
      check("sb1_expected_done", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("res1", pk(diff1, bout1, ovf1, zero1), e);
      end
    end
    if (done2) begin
      check("sb2_expected_done", 32'(q2.size() != 0), 1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        check("res2", pk(16'(diff2), bout2, ovf2, zero2), e);
      end
    end
  end

  task automatic op0(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
    @(negedge clk);
    a0 = a; b0 = b; bin0 = bi; start0 = 1'b1;
    q0.push_back(pk(16'(ed), eb, eo, ez));
    @(negedge clk);
    start0 = 1'b0;
    check("d0_busy_after_accept", 32'({busy0, done0}), 2);
    check("d0_hold_on_start", pk(16'(diff0), bout0, ovf0, zero0), prev0);
    a0 = ~a; b0 = ~b; bin0 = ~bi;
    for (int k = 1; k < N0; k++) begin
      @(negedge clk);
      check("d0_busy_run", 32'({busy0, done0}), 2);
    end
    @(negedge clk);
    check("d0_done_pulse", 32'({busy0, done0}), 1);
    @(negedge clk);
    check("d0_done_drop", 32'({busy0, done0}), 0);
    prev0 = pk(16'(ed), eb, eo, ez);
  endtask

  task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic bi);
    @(negedge clk);
    a1 = a; b1 = b; bin1 = bi; start1 = 1'b1;
    q1.push_back(model(16, int'(a), int'(b), int'(bi)));
    @(negedge clk);
    start1 = 1'b0;
    a1 = ~a;
    repeat (N1 - 1) @(negedge clk);
    check("d1_not_done_early", 32'(done1), 0);
    @(negedge clk);
    check("d1_done_at_n", 32'(done1), 1);
    @(negedge clk);
  endtask

  task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic bi);
    @(negedge clk);
    a2 = a; b2 = b; bin2 = bi; start2 = 1'b1;
    q2.push_back(model(8, int'(a), int'(b), int'(bi)));
    @(negedge clk);
    start2 = 1'b0;
    check("d2_busy_after_accept", 32'({busy2, done2}), 2);
    @(negedge clk);
    check("d2_done_pulse", 32'({busy2, done2}), 1);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] d;
    logic       bo;
    logic       ov;
    logic       z;
  } vec_t;

  vec_t vecs[7] = '{
    '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0},
    '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0},
    '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0},
    '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0},
    '{8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1},
    '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0},
    '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0}
  };

  logic [7:0] blist[16] = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h10, 8'h3C, 8'h55, 8'h7E,
                            8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC3, 8'hF0, 8'hFE, 8'hFF};

  initial begin
    int accepts[$];
    int exp_acc[3];
    logic prev_busy;
    exp_acc = '{0, 10, 20};

    // Reset: all three instances held, then released.
    repeat (3) @(negedge clk);
    check("rst0_outputs", pk(16'(diff0), bout0, ovf0, zero0), 0);
    check("rst0_busy_done", 32'({busy0, done0}), 0);
    check("rst1_outputs", pk(diff1, bout1, ovf1, zero1), 0);
    check("rst2_outputs", pk(16'(diff2), bout2, ovf2, zero2), 0);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // Directed 8-bit, DIGIT=1 vectors with cycle-exact handshake checks.
    foreach (vecs[i])
      op0(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].d, vecs[i].bo, vecs[i].ov, vecs[i].z);

    // start held high: accepts only at edges 0, 10, 20; mid-RUN a changes are ignored.
    @(negedge clk);
    a0 = 8'h10; b0 = 8'h01; bin0 = 1'b0; start0 = 1'b1;
    repeat (3) q0.push_back(pk(16'h000F, 1'b0, 1'b0, 1'b0));
    prev_busy = 1'b0;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      if (busy0 && !prev_busy) accepts.push_back(e);
      prev_busy = busy0;
      if (e == 3 || e == 13) a0 = 8'hFF;
      if (e == 7 || e == 17) a0 = 8'h10;
      if (e == 29) start0 = 1'b0;
    end
    check("hs_accept_count", 32'(accepts.size()), 3);
    for (int i = 0; i < 3; i++)
      if (i < accepts.size()) check("hs_accept_edge", 32'(accepts[i]), 32'(exp_acc[i]));
    check("hs_last_result", pk(16'(diff0), bout0, ovf0, zero0), pk(16'h000F, 1'b0, 1'b0, 1'b0));

    // Reset at edge 4 of a RUN: outputs cleared, no done pulse afterwards.
    @(negedge clk);
    a0 = 8'h55; b0 = 8'h11; bin0 = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    check("midrun_rst_outputs", pk(16'(diff0), bout0, ovf0, zero0), 0);
    check("midrun_rst_busy_done", 32'({busy0, done0}), 0);
    prev0 = '0;
    repeat (12) @(negedge clk);
    op0(8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0);

    // WIDTH=16, DIGIT=4: directed corners then random vectors.
    op1(16'h8000, 16'h0001, 1'b0);
    op1(16'h0000, 16'hFFFF, 1'b0);
    op1(16'h1234, 16'h1234, 1'b0);
    op1(16'h7FFF, 16'hFFFF, 1'b1);
    for (int i = 0; i < 1000; i++)
      op1(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));

    // WIDTH=8, DIGIT=8: every a against a spread of b values, both borrow-in values.
    for (int j = 0; j < 16; j++)
      for (int a = 0; a < 256; a++)
        for (int bi = 0; bi < 2; bi++)
          op2(8'(a), blist[j], 1'(bi));

    repeat (4) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 0);
    check("q1_drained", 32'(q1.size()), 0);
    check("q2_drained", 32'(q2.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
